// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the shift-add sequential multiplier.
// Optional abort support is controlled by SEQ_MUL_ABORT_EN.
package seq_mul_pkg;

    localparam int DEF_WIDTH_A = 8;
    localparam int DEF_WIDTH_B = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_run_ctrl.sv
// Run control: state register, iteration counter, terminal count.
// Adds an abort input when SEQ_MUL_ABORT_EN is defined.
module seq_mul_run_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH_B = DEF_WIDTH_B
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef SEQ_MUL_ABORT_EN
    input  logic abort,
`endif
    output logic load,
    output logic shift_en,
    output logic tc,
    output logic busy,
    output logic done
);

    localparam int CNT_W = cnt_width(WIDTH_B);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_B - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_i;

`ifdef SEQ_MUL_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign tc       = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign load     = start && (state_q != ST_RUN);
    assign shift_en = (state_q == ST_RUN) && !abort_i;
    assign busy     = busy_q;
    assign done     = done_q;

    // Next state and counter; abort outranks both tc and start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tc) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = start ? ST_RUN : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, counter and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/seq_mul_core.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// Defining SEQ_MUL_ABORT_EN adds an abort input that cancels a run.
module seq_mul_core
    import seq_mul_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
`ifdef SEQ_MUL_ABORT_EN
    input  logic                       abort,
`endif
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH_A+WIDTH_B-1:0] product
);

    logic                       load;
    logic                       shift_en;
    logic                       tc;
    logic [WIDTH_A-1:0]         mcand_q, mcand_d;
    logic [WIDTH_A:0]           acc_q, acc_d;
    logic [WIDTH_B-1:0]         mplr_q, mplr_d;
    logic [WIDTH_A+WIDTH_B-1:0] prod_q, prod_d;
    logic [WIDTH_A:0]           sum;
    logic [WIDTH_A+WIDTH_B:0]   shifted;

    seq_mul_run_ctrl #(
        .WIDTH_B (WIDTH_B)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef SEQ_MUL_ABORT_EN
        .abort    (abort),
`endif
        .load     (load),
        .shift_en (shift_en),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    assign product = prod_q;

    // Add-and-shift step; product captured on the final iteration
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        prod_d  = prod_q;
        sum     = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        shifted = {sum, mplr_q} >> 1;
        if (load) begin
            mcand_d = a;
            acc_d   = '0;
            mplr_d  = b;
            prod_d  = '0;
        end else if (shift_en) begin
            acc_d  = shifted[WIDTH_A+WIDTH_B:WIDTH_B];
            mplr_d = shifted[WIDTH_B-1:0];
            if (tc) begin
                prod_d = {acc_d[WIDTH_A-1:0], mplr_d};
            end
        end
`ifdef SEQ_MUL_ABORT_EN
        if (abort && busy) begin
            prod_d = '0;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_seq_mul_core.sv
// Self-checking bench for seq_mul_core (default 8x8 and a 16x4 instance).
// Abort scenarios are exercised when SEQ_MUL_ABORT_EN is defined.
module tb_seq_mul_core;

    localparam int WB = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start2;
    logic [15:0] a2;
    logic [3:0]  b2;
    logic        busy2;
    logic        done2;
    logic [19:0] product2;

`ifdef SEQ_MUL_ABORT_EN
    logic        abort;
    logic        abort2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [6];

    seq_mul_core #(.WIDTH_A(8), .WIDTH_B(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
`ifdef SEQ_MUL_ABORT_EN
        .abort   (abort),
`endif
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    seq_mul_core #(.WIDTH_A(16), .WIDTH_B(4)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
`ifdef SEQ_MUL_ABORT_EN
        .abort   (abort2),
`endif
        .a       (a2),
        .b       (b2),
        .busy    (busy2),
        .done    (done2),
        .product (product2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < WB + 4) begin
            tick();
            cyc++;
        end
    endtask

    task automatic watch_no_done(input int n, input string nm);
        int seen;
        seen = 0;
        repeat (n) begin
            tick();
            if (done) seen++;
        end
        check(nm, seen, 0);
    endtask

    task automatic run_check(input string nm, input logic [7:0] av,
                             input logic [7:0] bv, input logic [15:0] exp);
        int cyc;
        start_op(av, bv);
        check({nm, " busy@accept"}, busy, 1);
        check({nm, " prod_clr"}, product, 0);
        wait_done(cyc);
        check({nm, " latency"}, cyc, WB);
        check({nm, " product"}, product, exp);
        check({nm, " busy@done"}, busy, 0);
        tick();
        check({nm, " done_pulse"}, done, 0);
        check({nm, " held"}, product, exp);
    endtask

    initial begin
        int cyc;
        int ra;
        int rb;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};

        reset  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
`ifdef SEQ_MUL_ABORT_EN
        abort  = 1'b0;
        abort2 = 1'b0;
`endif
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst product", product, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // table vectors
        for (int i = 0; i < 6; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                      vecs[i].p);
        end

        // random operands against plain multiplication
        for (int i = 0; i < 16; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run_check($sformatf("rnd%0d", i), 8'(ra), 8'(rb),
                      16'(ra * rb));
        end

        // start held high: ignored in RUN, restarts from DONE
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        tick();
        a = 8'd7;
        b = 8'd9;
        wait_done(cyc);
        check("hold first latency", cyc, WB);
        check("hold first product", product, 15);
        tick();
        check("hold restart busy", busy, 1);
        check("hold restart clr", product, 0);
        start = 1'b0;
        wait_done(cyc);
        check("hold second latency", cyc, WB);
        check("hold second product", product, 63);
        tick();
        check("hold after done", done, 0);
        check("hold product kept", product, 63);
        tick();

        // start pulse during RUN is ignored
        start_op(8'd9, 8'd7);
        repeat (3) tick();
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("midstart latency", cyc, WB - 4);
        check("midstart product", product, 63);
        watch_no_done(WB + 3, "midstart extra done");
        check("midstart held", product, 63);

        // asynchronous reset in the middle of a run
        start_op(8'd50, 8'd60);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst product", product, 0);
        @(negedge clk);
        reset = 1'b1;
        watch_no_done(WB + 3, "midrst no done");
        check("midrst idle", busy, 0);
        run_check("after rst", 8'd6, 8'd7, 16'd42);

`ifdef SEQ_MUL_ABORT_EN
        // abort after five iterations
        start_op(8'd100, 8'd100);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort product", product, 0);
        watch_no_done(WB + 2, "abort no done");

        // abort on the terminal-count edge
        start_op(8'd200, 8'd3);
        repeat (WB - 1) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort tc busy", busy, 0);
        check("abort tc done", done, 0);
        check("abort tc product", product, 0);
        watch_no_done(WB + 2, "abort tc no done");
        run_check("after abort", 8'd12, 8'd12, 16'd144);
`endif

        // 16x4 instance
        a2     = 16'hFFFF;
        b2     = 4'hF;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        check("w16 busy", busy2, 1);
        cyc = 0;
        while (!done2 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("w16 latency", cyc, 4);
        check("w16 product", product2, 983025);
        tick();
        check("w16 done pulse", done2, 0);
        check("w16 held", product2, 983025);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_mul_core.md
Name: seq_mul_core

Overview:
- Parametrised unsigned shift-add sequential multiplier with a start/busy/done handshake.
- Next generation of the single-bit run-flag control used by the fixed-width multiplier. The run flag, internal terminal counter and datapath are integrated.
- Sits between a host that issues operands and whatever consumes the registered product.
- Processes one multiplier bit per clock.

Parameters:
- WIDTH_A, 8, multiplicand width (bits), >=2
- WIDTH_B, 8, multiplier width (bits), >=2; also the iteration count
- CNT_W, $clog2(WIDTH_B), iteration counter width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  request; sampled on rising clk
- a  input  WIDTH_A  multiplicand; captured when start is accepted
- b  input  WIDTH_B  multiplier; captured when start is accepted
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; product valid
- product  output  WIDTH_A+WIDTH_B  result; held until next accepted start

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, product=0; counter=0; internal regs=0.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when tc.
  - DONE -> IDLE, or DONE -> RUN if start=1.
- Start acceptance: accepted only when state!=RUN (IDLE or DONE). start during RUN is ignored, not queued.
- On accept edge:
  - mcand<=a; acc_hi<=0 (WIDTH_A+1 bits incl. carry); mplr<=b; counter<=0.
  - product is cleared to 0.
- Each RUN edge:
  - if mplr[0]: sum = acc_hi + mcand, else sum = acc_hi.
  - {acc_hi, mplr} <= {sum, mplr} >> 1 (logical, carry shifted in).
  - counter += 1.
- tc = (state==RUN) && (counter==WIDTH_B-1). The edge on which tc is high performs the last iteration and enters DONE.
- DONE: done=1 for exactly one cycle; product = {acc_hi[WIDTH_A-1:0], mplr}; busy=0.
- busy=1 exactly in RUN.
- Latency: start sampled at edge k; done high in the cycle after edge k+WIDTH_B; WIDTH_B+1 cycles total.
- Throughput: back-to-back start in DONE gives one result per WIDTH_B+1 cycles.
- No overflow is possible: the full-width product is always exact.
- Operands a/b may change freely after the accept edge.
- Reset mid-RUN: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: SEQ_MUL_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort=1 at an edge while in RUN -> IDLE; busy=0; product=0; no done.
  - abort and tc on the same edge: abort wins.
  - abort outside RUN is ignored. abort outranks start on the same edge.
- Undefined: no abort port; RUN always completes WIDTH_B iterations.

Decomposition:
- Shared package seq_mul_pkg:
  - state typedef (IDLE, RUN, DONE; 2-bit encoding).
  - Localparams for default widths.
  - Function for counter width.
- One natural sub-module, seq_mul_run_ctrl:
  - Holds state register, iteration counter and tc generation.
  - Outputs load, shift_en, busy, done.
  - Parametrised by WIDTH_B; the datapath stays in seq_mul_core.

Test Plan:
- Defaults, a=13, b=11, start one cycle -> busy for 8 cycles; done pulses 9 cycles after the start edge; product=143.
- a=255, b=255 -> product=65025. a=0, b=200 -> 0. a=200, b=0 -> 0. done asserted in every case.
- start held high continuously:
  - pulses at RUN entry ignored; results every 9 cycles.
  - a=3,b=5 then a=7,b=9 -> 15 then 63, with product held between.
- start pulsed 3 cycles after acceptance -> no effect; single done; result unchanged.
- reset=0 at cycle 4 of RUN -> busy, done, product go 0 immediately; no done afterwards; next start computes correctly.
- Abort (SEQ_MUL_ABORT_EN defined):
  - abort at iteration 5 -> IDLE next cycle, no done, product=0.
  - abort coincident with tc -> no done.
- WIDTH_A=16, WIDTH_B=4: a=65535, b=15 -> product=983025; done 5 cycles after start.
